uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_sched_rr_arb2.sv | 24 ++
 rtl/uart_tx_sched.sv | 130 +++++++++++++
 tb/tb_uart_tx_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
//   sched_state_e    : scheduler FSM states
//   tx_slot_t        : byte + requester index presented to uart_tx
//   FRAME_CYCLES_DEF : default clk cycles per uart_tx frame (start + 8 data + stop)
//   CNT_W            : width of the frame-slot down-counter
package uart_pkg;

    localparam int FRAME_CYCLES_DEF = 10;
    localparam int CNT_W            = 5;

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        IDLE    = 2'd1,
        WAIT    = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       id;
    } tx_slot_t;

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
//   valid[1:0] : requester valids
//   last       : index granted most recently
//   grant      : winning index (0 when nobody is valid)
//   any_valid  : at least one requester is valid
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant,
    output logic       any_valid
);

    always_comb begin
        any_valid = |valid;
        grant     = 1'b0;
        if (&valid) begin
            // Contention: whoever did not win last time goes now.
            grant = ~last;
        end else begin
            grant = valid[1];
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler in front of a uart_tx.
// Picks a requester round-robin, hands its byte to uart_tx with a one-cycle
// trigger, then blocks new accepts for one frame slot (frame + gap).
//   clk, rst               : clock, asynchronous active-high reset
//   reqN_valid/data/ready  : valid/ready byte inputs from requester N
//   tx_data, tx_trig       : registered byte and start pulse to uart_tx
//   busy                   : high from accept until the frame slot ends
//   grant_id               : requester index of the byte on tx_data
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int GAP_CYCLES   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_trig,
    output logic       busy,
    output logic       grant_id
);

    // The slot counter never wraps, and WAIT needs at least one cycle.
    if ((FRAME_CYCLES + GAP_CYCLES) > 31 || (FRAME_CYCLES + GAP_CYCLES) < 2 ||
        GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_param_err
        $error("uart_tx_sched: FRAME_CYCLES/GAP_CYCLES out of range");
    end

    localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES);
    // WAIT lasts FRAME+GAP-1 cycles so the next accept lands FRAME+GAP
    // cycles after the previous one.
    localparam logic [CNT_W-1:0] SLOT_LOAD  = CNT_W'(FRAME_CYCLES + GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    tx_slot_t         slot_q, slot_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic             last_q, last_d;

    logic             grant;
    logic             any_valid;

    rr_arb2 u_arb (
        .valid     ({req1_valid, req0_valid}),
        .last      (last_q),
        .grant     (grant),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STARTUP;
            cnt_q   <= FRAME_LOAD;
            slot_q  <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        trig_d     = 1'b0;
        busy_d     = busy_q;
        last_d     = last_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        unique case (state_q)
            // Hold off long enough for a frame cut short by reset to drain.
            STARTUP: begin
                if (cnt_q <= CNT_ONE) state_d = IDLE;
                else                  cnt_d   = cnt_q - CNT_ONE;
            end
            IDLE: begin
                if (any_valid) begin
                    req0_ready  = ~grant;
                    req1_ready  = grant;
                    slot_d.data = grant ? req1_data : req0_data;
                    slot_d.id   = grant;
                    trig_d      = 1'b1;
                    busy_d      = 1'b1;
                    last_d      = grant;
                    cnt_d       = SLOT_LOAD;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = STARTUP;
        endcase
    end

    assign tx_data  = slot_q.data;
    assign grant_id = slot_q.id;
    assign tx_trig  = trig_q;
    assign busy     = busy_q;

    // Requesters must not change a byte they are still offering.
    a_req0_stable: assert property (@(posedge clk) disable iff (rst)
        (req0_valid && $past(req0_valid && !req0_ready)) |-> (req0_data == $past(req0_data)));
    a_req1_stable: assert property (@(posedge clk) disable iff (rst)
        (req1_valid && $past(req1_valid && !req1_ready)) |-> (req1_data == $past(req1_data)));
    a_trig_single: assert property (@(posedge clk) disable iff (rst)
        tx_trig |=> !tx_trig);

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // instance A: GAP_CYCLES = 0
    logic       a_v0 = 1'b0, a_v1 = 1'b0;
    logic [7:0] a_d0 = 8'h00, a_d1 = 8'h00;
    logic       a_r0, a_r1, a_trig, a_busy, a_gid;
    logic [7:0] a_txdata;
    // instance B: GAP_CYCLES = 3
    logic       b_v0 = 1'b0, b_v1 = 1'b0;
    logic [7:0] b_d0 = 8'h00, b_d1 = 8'h00;
    logic       b_r0, b_r1, b_trig, b_busy, b_gid;
    logic [7:0] b_txdata;

    uart_tx_sched #(.FRAME_CYCLES(10), .GAP_CYCLES(0)) u_dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
        .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
        .tx_data(a_txdata), .tx_trig(a_trig), .busy(a_busy), .grant_id(a_gid)
    );

    uart_tx_sched #(.FRAME_CYCLES(10), .GAP_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
        .tx_data(b_txdata), .tx_trig(b_trig), .busy(b_busy), .grant_id(b_gid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Minimal uart_tx models: load on trig, emit start, 8 data LSB first, stop.
    logic [9:0] a_sh = 10'h3FF, b_sh = 10'h3FF;
    int         a_cnt = 0, b_cnt = 0;
    logic       a_txd, b_txd;
    always @(posedge clk) begin
        if (a_trig) begin a_sh <= {1'b1, a_txdata, 1'b0}; a_cnt <= 10; end
        else if (a_cnt > 0) begin a_sh <= {1'b1, a_sh[9:1]}; a_cnt <= a_cnt - 1; end
        if (b_trig) begin b_sh <= {1'b1, b_txdata, 1'b0}; b_cnt <= 10; end
        else if (b_cnt > 0) begin b_sh <= {1'b1, b_sh[9:1]}; b_cnt <= b_cnt - 1; end
    end
    assign a_txd = (a_cnt != 0) ? a_sh[0] : 1'b1;
    assign b_txd = (b_cnt != 0) ? b_sh[0] : 1'b1;

    // Trig / line logs, indexed by cycle number.
    int         a_tc[$], b_tc[$];
    logic [7:0] a_td[$];
    logic       a_ti[$];
    logic       a_hist[0:2047];
    logic       b_hist[0:2047];
    always @(negedge clk) begin
        if (a_trig) begin a_tc.push_back(cyc); a_td.push_back(a_txdata); a_ti.push_back(a_gid); end
        if (b_trig) b_tc.push_back(cyc);
        if (cyc < 2048) begin a_hist[cyc] <= a_txd; b_hist[cyc] <= b_txd; end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    function automatic logic [7:0] rx_a(input int tc);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = a_hist[tc + 2 + i];
        return r;
    endfunction

    task automatic chk_trig(input int idx, input int ec, input logic [7:0] ed,
                            input logic ei, input bit do_rx);
        if (idx >= a_tc.size()) begin
            chk($sformatf("trig%0d_present", idx), a_tc.size(), idx + 1);
        end else begin
            chk($sformatf("trig%0d_cyc", idx), a_tc[idx], ec);
            chk($sformatf("trig%0d_data", idx), a_td[idx], ed);
            chk($sformatf("trig%0d_id", idx), a_ti[idx], ei);
            if (do_rx) begin
                chk($sformatf("trig%0d_start", idx), a_hist[a_tc[idx] + 1], 0);
                chk($sformatf("trig%0d_rx", idx), rx_a(a_tc[idx]), ed);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, s, t, u, c1, g, n;
        logic [9:0] bits;
        logic [2:0] gap;

        a_d0 = 8'hA5;
        a_v0 = 1'b1;
        #1 rst = 1'b1;
        smp();
        chk("rst_trig", a_trig, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_data", a_txdata, 0);
        chk("rst_gid", a_gid, 0);
        chk("rst_ready0", a_r0, 0);

        // Single byte from req0 after STARTUP.
        at(3); rst = 1'b0; c0 = 3;
        at(c0 + 9);  smp(); chk("startup_ready0", a_r0, 0); chk("startup_busy", a_busy, 0);
        at(c0 + 10); smp(); chk("idle_ready0", a_r0, 1); chk("idle_ready1", a_r1, 0);
        at(c0 + 11); a_v0 = 1'b0;
        smp();
        chk("a5_trig", a_trig, 1); chk("a5_data", a_txdata, 8'hA5);
        chk("a5_gid", a_gid, 0);   chk("a5_busy", a_busy, 1);
        at(c0 + 12); smp(); chk("trig_one_cycle", a_trig, 0);

        // One-cycle valid pulse while WAITing is ignored.
        at(c0 + 15); a_d1 = 8'h77; a_v1 = 1'b1;
        smp(); chk("wait_ready1", a_r1, 0);
        at(c0 + 16); a_v1 = 1'b0;
        at(c0 + 19); smp(); chk("busy_in_slot", a_busy, 1);
        at(c0 + 20); smp(); chk("busy_drop", a_busy, 0); chk("idle_no_ready", a_r1, 0);
        at(c0 + 23);
        for (int i = 0; i < 10; i++) bits[i] = a_hist[c0 + 12 + i];
        chk("a5_txd", bits, 10'b1101001010); // start 0, A5 LSB first, stop 1
        chk("pulse_no_trig", a_tc.size(), 1);

        // Only req1 valid for three bytes.
        s = c0 + 26;
        at(s);      a_d1 = 8'h31; a_v1 = 1'b1;
        at(s + 1);  a_d1 = 8'h32;
        at(s + 11); a_d1 = 8'h33;
        at(s + 21); a_v1 = 1'b0;

        // Both requesters valid continuously: grants alternate starting with req0.
        t = s + 30;
        at(t);      a_d0 = 8'h11; a_v0 = 1'b1; a_d1 = 8'h22; a_v1 = 1'b1;
        at(t + 31); a_v0 = 1'b0; a_v1 = 1'b0;
        at(t + 42);
        chk_trig(1, s + 1,  8'h31, 1'b1, 1'b1);
        chk_trig(2, s + 11, 8'h32, 1'b1, 1'b1);
        chk_trig(3, s + 21, 8'h33, 1'b1, 1'b1);
        chk_trig(4, t + 1,  8'h11, 1'b0, 1'b1);
        chk_trig(5, t + 11, 8'h22, 1'b1, 1'b1);
        chk_trig(6, t + 21, 8'h11, 1'b0, 1'b1);
        chk_trig(7, t + 31, 8'h22, 1'b1, 1'b1);

        // Reset during the data bits of a frame, with req0 pending.
        u = t + 42;
        at(u);     a_d1 = 8'h5A; a_v1 = 1'b1;
        at(u + 1); a_v1 = 1'b0;
        at(u + 2); a_d0 = 8'hC3; a_v0 = 1'b1;
        at(u + 4);
        n = a_tc.size();
        #2 rst = 1'b1;
        #1;
        chk("async_busy", a_busy, 0);
        chk("async_data", a_txdata, 0);
        chk("async_gid", a_gid, 0);
        chk("async_trig", a_trig, 0);
        chk("async_ready0", a_r0, 0);
        at(u + 6); rst = 1'b0; c1 = u + 6;
        at(c1 + 9);  smp(); chk("rst_startup_ready0", a_r0, 0);
        at(c1 + 10); smp(); chk("rst_idle_ready0", a_r0, 1);
        at(c1 + 11); a_v0 = 1'b0;
        smp(); chk("rst_no_early_trig", a_tc.size(), n + 1);
        chk_trig(8, u + 1, 8'h5A, 1'b1, 1'b0);

        // GAP_CYCLES = 3, single requester.
        g = c1 + 15;
        at(g);      b_d0 = 8'h96; b_v0 = 1'b1;
        at(g + 12); smp(); chk("gap_busy_hold", b_busy, 1);
        at(g + 13); smp(); chk("gap_busy_drop", b_busy, 0); chk("gap_ready0", b_r0, 1);
        at(g + 14); b_v0 = 1'b0;
        at(g + 30);
        chk("gap_trig_count", b_tc.size(), 2);
        if (b_tc.size() >= 2) begin
            chk("gap_trig0_cyc", b_tc[0], g + 1);
            chk("gap_spacing", b_tc[1] - b_tc[0], 13);
        end
        for (int i = 0; i < 3; i++) gap[i] = b_hist[g + 12 + i];
        chk("gap_idle_high", gap, 3'b111);
        chk("gap_next_start", b_hist[g + 15], 0);
        chk_trig(9, c1 + 11, 8'hC3, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
